// File: rtl/uart_baud_pkg.sv
// Shared types and helpers for the UART baud generator.
package uart_baud_pkg;

  // Control state of the generator.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } baud_state_e;

  // Phase increment for a given baud:
  // round(baud * os * 2^acc_w / clk_hz), using 64-bit math.
  function automatic logic [63:0] baud_inc(
    input logic [63:0] clk_hz,
    input logic [63:0] baud,
    input logic [63:0] os,
    input int unsigned acc_w
  );
    logic [63:0] num;
    num = (baud * os) << acc_w;
    return (num + (clk_hz >> 1)) / clk_hz;
  endfunction

  // Increment for the default build: 100 MHz clock, 9600 baud, 16x oversample, 32-bit phase.
  localparam logic [63:0] DEFAULT_INC = baud_inc(64'd100_000_000, 64'd9600, 64'd16, 32);

endpackage

// File: rtl/uart_baud_gen_phase_acc.sv
// Fractional phase accumulator: adds inc every enabled cycle and reports the overflow.
module baud_phase_acc #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             carry
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  // Next phase: clear has priority, otherwise advance by inc when enabled.
  // The carry only counts when the add is actually committed.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc};
    acc_d = acc_q;
    carry = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[ACC_W-1:0];
      carry = sum[ACC_W];
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: NCO-driven oversample strobe, bit strobe and baud square wave,
// with a runtime increment load port and a phase re-align input for RX mid-bit sampling.
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned ACC_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             baud_clk
);

  localparam int unsigned      CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [ACC_W-1:0] RST_INC  =
    ACC_W'(baud_inc(64'(CLK_HZ), 64'(DEFAULT_BAUD), 64'(OVERSAMPLE), ACC_W));

  baud_state_e      state_q, state_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             baud_clk_q, baud_clk_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic cfg_fire;
  logic run_adv;
  logic acc_adv;
  logic acc_clr;
  logic carry;

  // A config handshake pre-empts everything; the phase only advances while running
  // undisturbed, and any other cycle holds it at zero.
  assign cfg_fire = cfg_valid & cfg_ready_q;
  assign run_adv  = (state_q == RUN) & en & ~cfg_fire;
  assign acc_adv  = run_adv & ~sync;
  assign acc_clr  = ~acc_adv;

  baud_phase_acc #(
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .en    (acc_adv),
    .inc   (inc_q),
    .carry (carry)
  );

  // Next-state, counter and strobe computation.
  always_comb begin
    state_d = cfg_fire ? LOAD : (en ? RUN : IDLE);
    inc_d   = cfg_fire ? cfg_inc : inc_q;

    os_cnt_d = '0;
    if (run_adv) begin
      if (sync) begin
        os_cnt_d = CNT_HALF;
      end else if (carry) begin
        os_cnt_d = os_cnt_q + CNT_W'(1);
      end else begin
        os_cnt_d = os_cnt_q;
      end
    end

    // carry is only ever set on a committed RUN add, so strobes cannot leak out of RUN.
    os_tick_d   = carry;
    bit_tick_d  = carry & (os_cnt_q == CNT_LAST);
    baud_clk_d  = (state_d == RUN) & (os_cnt_d >= CNT_HALF);
    cfg_ready_d = (state_d != LOAD);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      os_tick_q   <= 1'b0;
      bit_tick_q  <= 1'b0;
      baud_clk_q  <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      os_tick_q   <= os_tick_d;
      bit_tick_q  <= bit_tick_d;
      baud_clk_q  <= baud_clk_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  // Oversample counter within the current bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt_q <= '0;
    end else begin
      os_cnt_q <= os_cnt_d;
    end
  end

  // Active phase increment; reset restores the build-time default baud.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q <= RST_INC;
    end else begin
      inc_q <= inc_d;
    end
  end

  assign os_tick   = os_tick_q;
  assign bit_tick  = bit_tick_q;
  assign baud_clk  = baud_clk_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a phase-arithmetic reference model.
module tb_uart_baud_gen;

  localparam int              OS      = 16;
  localparam longint unsigned TWO_ACC = 64'h1_0000_0000;
  localparam longint unsigned DEF_INC = (64'd153600 * TWO_ACC + 64'd50_000_000) / 64'd100_000_000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic [31:0] cfg_inc = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        os_tick;
  logic        bit_tick;
  logic        baud_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 running, 2 loading.
  int              m_mode  = 0;
  longint unsigned m_inc   = DEF_INC;
  longint unsigned m_phase = 0;
  int              m_os    = 0;
  logic [3:0]      m_exp   = 4'b0001;

  uart_baud_gen #(
    .CLK_HZ       (100_000_000),
    .DEFAULT_BAUD (9600),
    .OVERSAMPLE   (16),
    .ACC_W        (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_inc   (cfg_inc),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .os_tick   (os_tick),
    .bit_tick  (bit_tick),
    .baud_clk  (baud_clk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    logic tk;
    logic bt;
    tk = 1'b0;
    bt = 1'b0;
    if (rst) begin
      m_mode = 0; m_inc = DEF_INC; m_phase = 0; m_os = 0;
    end else if (cfg_valid && m_mode != 2) begin
      m_inc = 64'(cfg_inc); m_phase = 0; m_os = 0; m_mode = 2;
    end else if (m_mode == 1 && en) begin
      if (sync) begin
        m_phase = 0; m_os = OS / 2;
      end else begin
        m_phase = m_phase + m_inc;
        if (m_phase >= TWO_ACC) begin
          m_phase = m_phase - TWO_ACC;
          tk = 1'b1;
          m_os = m_os + 1;
          if (m_os == OS) begin
            m_os = 0;
            bt = 1'b1;
          end
        end
      end
    end else begin
      m_phase = 0; m_os = 0; m_mode = en ? 1 : 0;
    end
    m_exp = {tk, bt, (m_mode == 1 && m_os >= OS / 2), (m_mode != 2)};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("outs", 64'({os_tick, bit_tick, baud_clk, cfg_ready}), 64'(m_exp));
  endtask

  task automatic wait_os(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!os_tick && n < budget);
    chk("os_seen", 64'(os_tick), 64'd1);
  endtask

  task automatic wait_bit(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bit_tick && n < budget);
    chk("bit_seen", 64'(bit_tick), 64'd1);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (baud_clk == lvl && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int osi;
    int last_bit;
    int nt;

    // Reset
    repeat (3) step();
    chk("rst_ready", 64'(cfg_ready), 64'd1);
    chk("rst_outs", 64'({os_tick, bit_tick, baud_clk}), 64'd0);

    // Default baud: 651/652-cycle oversample period, bit tick every 16th
    rst = 1'b0;
    en  = 1'b1;
    wait_os(700, n);
    osi = 0;
    last_bit = -1;
    for (int i = 0; i < 40; i++) begin
      wait_os(700, n);
      osi++;
      chk("t1_period", 64'(n == 651 || n == 652), 64'd1);
      if (bit_tick) begin
        if (last_bit >= 0) chk("t1_bit16", 64'(osi - last_bit), 64'd16);
        last_bit = osi;
      end
    end

    // Quarter-scale increment: exact 4-cycle ticks
    cfg_valid = 1'b1;
    cfg_inc   = 32'h4000_0000;
    step();
    cfg_valid = 1'b0;
    chk("t2_ready_lo", 64'(cfg_ready), 64'd0);
    step();
    chk("t2_ready_hi", 64'(cfg_ready), 64'd1);
    wait_bit(100, n);
    for (int i = 0; i < 2; i++) begin
      wait_bit(100, n);
      chk("t2_bit64", 64'(n), 64'd64);
    end
    for (int i = 0; i < 4; i++) begin
      wait_os(10, n);
      chk("t2_os4", 64'(n), 64'd4);
    end
    run_len(1'b1, n);
    run_len(1'b0, n);
    run_len(1'b1, n);
    chk("t2_baud_hi", 64'(n), 64'd32);
    run_len(1'b0, n);
    chk("t2_baud_lo", 64'(n), 64'd32);

    // Phase re-align mid-bit
    repeat (13) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    wait_bit(100, n);
    chk("t3_sync32", 64'(n), 64'd32);
    wait_bit(100, n);
    chk("t3_then64", 64'(n), 64'd64);

    // Disable mid-bit, then re-enable
    repeat (10) step();
    en = 1'b0;
    step();
    chk("t4_stop", 64'({os_tick, bit_tick, baud_clk}), 64'd0);
    repeat (20) step();
    en  = 1'b1;
    osi = 0;
    n   = 0;
    do begin
      step();
      n++;
      if (os_tick) osi++;
    end while (!bit_tick && n < 200);
    chk("t4_first_bit", 64'(osi), 64'd16);

    // Zero increment loaded together with sync: cfg wins, then a legal stall
    repeat (7) step();
    cfg_valid = 1'b1;
    cfg_inc   = 32'h0;
    sync      = 1'b1;
    step();
    cfg_valid = 1'b0;
    sync      = 1'b0;
    step();
    step();
    chk("t5_cfg_wins", 64'(baud_clk), 64'd0);
    nt = 0;
    repeat (10000) begin
      step();
      if (os_tick || bit_tick) nt++;
    end
    chk("t5_no_ticks", 64'(nt), 64'd0);

    // Reset during RUN with a pending config
    cfg_valid = 1'b1;
    cfg_inc   = 32'h4000_0000;
    step();
    cfg_valid = 1'b0;
    repeat (50) step();
    cfg_valid = 1'b1;
    cfg_inc   = 32'd123;
    rst       = 1'b1;
    step();
    chk("t6_rst_outs", 64'({os_tick, bit_tick, baud_clk}), 64'd0);
    chk("t6_rst_ready", 64'(cfg_ready), 64'd1);
    rst       = 1'b0;
    cfg_valid = 1'b0;
    wait_os(700, n);
    wait_os(700, n);
    chk("t6_def_period", 64'(n == 651 || n == 652), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 19) != 0);
      sync      = ($urandom_range(0, 49) == 0);
      cfg_valid = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0:       cfg_inc = 32'hFFFF_FFFF;
        1:       cfg_inc = 32'h8000_0000;
        default: cfg_inc = $urandom_range(32'h0800_0000, 32'h8000_0000);
      endcase
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0; en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
